// File: rtl/fetch_stage.sv
// IF stage: PC register with prioritised next-PC select, registered-read imem addressing,
// IF/ID pipeline register with bubble insertion, and saturating fetch/stall/flush counters.
module fetch_stage #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       PC_W      = 32,
  parameter logic [PC_W-1:0]   RESET_PC  = '0,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0,
  parameter int unsigned       CNT_W     = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              pc_hold,
  input  logic              ifid_hold,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_target,
  input  logic              jump,
  input  logic [PC_W-1:0]   jump_target,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [PC_W-1:0]   ifid_pc,
  output logic [DATA_W-1:0] ifid_instr,
  output logic              ifid_valid,
  output logic [CNT_W-1:0]  fetch_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic {BOOT, RUN} state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [PC_W-1:0]     ifid_pc_q, ifid_pc_d;
  logic [DATA_W-1:0]   ifid_instr_q, ifid_instr_d;
  logic                ifid_valid_q, ifid_valid_d;
  logic [CNT_W-1:0]    fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
  logic [PC_W-1:0]     br_tgt, jp_tgt;
  logic                flush;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  assign br_tgt = branch_target & ~PC_W'(3);
  assign jp_tgt = jump_target & ~PC_W'(3);

  // State register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_q <= BOOT;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // Outputs: in RUN the memory is addressed with next_pc so imem_rdata lines up with pc_q
  always_comb begin
    imem_addr = pc_q;
    if (state_q == RUN) imem_addr = pc_d;
  end

  always_comb begin
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    fetch_cnt_d  = fetch_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    flush        = 1'b0;
    if (state_q == BOOT) begin
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else begin
      if (branch_taken) begin
        pc_d  = br_tgt;
        flush = 1'b1;
      end else if (jump && !ifid_hold) begin
        pc_d  = jp_tgt;
        flush = 1'b1;
      end else if (pc_hold) begin
        stall_cnt_d = sat_inc(stall_cnt_q);
      end else begin
        pc_d = pc_q + PC_W'(4);
      end

      if (flush) begin
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
        flush_cnt_d  = sat_inc(flush_cnt_q);
      end else if (!ifid_hold) begin
        ifid_pc_d    = pc_q;
        ifid_instr_d = imem_rdata;
        ifid_valid_d = 1'b1;
        fetch_cnt_d  = sat_inc(fetch_cnt_q);
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pc_q         <= RESET_PC;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      fetch_cnt_q  <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      fetch_cnt_q  <= fetch_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign ifid_pc    = ifid_pc_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_valid = ifid_valid_q;
  assign fetch_cnt  = fetch_cnt_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: vector table with a scoreboard queue for IF/ID results, plus
// hand sequences for counter saturation, PC wrap and asynchronous mid-run reset.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        pc_hold, ifid_hold, branch_taken, jump;
  logic [31:0] branch_target, jump_target;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] ifid_pc, ifid_instr;
  logic        ifid_valid;
  logic [31:0] fetch_cnt, stall_cnt, flush_cnt;

  logic [31:0] sat_imem_addr, sat_ifid_pc, sat_ifid_instr;
  logic        sat_ifid_valid;
  logic [3:0]  sat_fetch, sat_stall, sat_flush;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instruction memory: word k holds 0x1000 + k, one-cycle registered read
  always @(posedge clk) imem_rdata <= 32'h1000 + (imem_addr >> 2);

  fetch_stage #(.DATA_W(32), .PC_W(32), .RESET_PC(32'h0), .NOP_INSTR(32'h0), .CNT_W(32)) u_dut (
    .clk(clk), .arst_n(arst_n), .pc_hold(pc_hold), .ifid_hold(ifid_hold),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ifid_pc(ifid_pc), .ifid_instr(ifid_instr), .ifid_valid(ifid_valid),
    .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  fetch_stage #(.DATA_W(32), .PC_W(32), .RESET_PC(32'h0), .NOP_INSTR(32'h0), .CNT_W(4)) u_sat (
    .clk(clk), .arst_n(arst_n), .pc_hold(pc_hold), .ifid_hold(ifid_hold),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_addr(sat_imem_addr), .imem_rdata(imem_rdata),
    .ifid_pc(sat_ifid_pc), .ifid_instr(sat_ifid_instr), .ifid_valid(sat_ifid_valid),
    .fetch_cnt(sat_fetch), .stall_cnt(sat_stall), .flush_cnt(sat_flush)
  );

  typedef struct {
    logic        ph, ih, br;
    logic [31:0] bt;
    logic        j;
    logic [31:0] jt;
    logic [31:0] addr, pc, instr;
    logic        v;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] pc, instr;
    logic        v;
  } exp_t;

  vec_t tbl[20];
  exp_t sb[$];

  function automatic vec_t mk(logic ph, logic ih, logic br, logic [31:0] bt, logic j,
                              logic [31:0] jt, logic [31:0] addr, logic [31:0] pc,
                              logic [31:0] instr, logic v);
    vec_t r;
    r.ph = ph; r.ih = ih; r.br = br; r.bt = bt; r.j = j; r.jt = jt;
    r.addr = addr; r.pc = pc; r.instr = instr; r.v = v;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ph, input logic ih, input logic br, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt);
    pc_hold = ph; ifid_hold = ih; branch_taken = br; branch_target = bt;
    jump = j; jump_target = jt;
  endtask

  task automatic cycle(input logic ph, input logic ih, input logic br, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt);
    @(negedge clk);
    drive(ph, ih, br, bt, j, jt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    // ph ih br bt j jt | imem_addr ifid_pc ifid_instr valid
    tbl[0]  = mk(0,0,0,0,0,0,            32'h000, 32'h000, 32'h0000, 0); // BOOT
    tbl[1]  = mk(0,0,0,0,0,0,            32'h004, 32'h000, 32'h1000, 1);
    tbl[2]  = mk(0,0,0,0,0,0,            32'h008, 32'h004, 32'h1001, 1);
    tbl[3]  = mk(0,0,0,0,0,0,            32'h00C, 32'h008, 32'h1002, 1);
    tbl[4]  = mk(0,0,0,0,0,0,            32'h010, 32'h00C, 32'h1003, 1);
    tbl[5]  = mk(1,1,0,0,0,0,            32'h010, 32'h00C, 32'h1003, 1); // load-use stall
    tbl[6]  = mk(1,1,0,0,0,0,            32'h010, 32'h00C, 32'h1003, 1);
    tbl[7]  = mk(0,0,0,0,0,0,            32'h014, 32'h010, 32'h1004, 1);
    tbl[8]  = mk(1,1,1,32'h40,0,0,       32'h040, 32'h000, 32'h0000, 0); // branch beats holds
    tbl[9]  = mk(0,0,0,0,0,0,            32'h044, 32'h040, 32'h1010, 1);
    tbl[10] = mk(1,1,0,0,1,32'h80,       32'h044, 32'h040, 32'h1010, 1); // jump ignored
    tbl[11] = mk(0,0,0,0,1,32'h80,       32'h080, 32'h000, 32'h0000, 0);
    tbl[12] = mk(0,0,0,0,0,0,            32'h084, 32'h080, 32'h1020, 1);
    tbl[13] = mk(0,0,1,32'h100,1,32'h200,32'h100, 32'h000, 32'h0000, 0); // branch over jump
    tbl[14] = mk(0,0,0,0,0,0,            32'h104, 32'h100, 32'h1040, 1);
    tbl[15] = mk(0,0,1,32'h103,0,0,      32'h100, 32'h000, 32'h0000, 0); // unaligned target
    tbl[16] = mk(0,0,0,0,0,0,            32'h104, 32'h100, 32'h1040, 1);
    tbl[17] = mk(1,0,0,0,1,32'h2A2,      32'h2A0, 32'h000, 32'h0000, 0); // jump beats pc_hold
    tbl[18] = mk(1,0,0,0,0,0,            32'h2A0, 32'h2A0, 32'h10A8, 1); // duplicate capture
    tbl[19] = mk(0,0,0,0,0,0,            32'h2A4, 32'h2A0, 32'h10A8, 1);

    arst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_addr",  imem_addr,  32'h0);
    chk("rst_pc",    ifid_pc,    32'h0);
    chk("rst_instr", ifid_instr, 32'h0);
    chk("rst_valid", {31'b0, ifid_valid}, 32'h0);
    chk("rst_fetch", fetch_cnt,  32'h0);
    chk("rst_stall", stall_cnt,  32'h0);
    chk("rst_flush", flush_cnt,  32'h0);
    @(posedge clk);
    #3 arst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(tbl[i].ph, tbl[i].ih, tbl[i].br, tbl[i].bt, tbl[i].j, tbl[i].jt);
      #1;
      chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].addr);
      e.idx = i; e.pc = tbl[i].pc; e.instr = tbl[i].instr; e.v = tbl[i].v;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d_valid", e.idx), {31'b0, ifid_valid}, {31'b0, e.v});
      chk($sformatf("v%0d_instr", e.idx), ifid_instr, e.instr);
      if (e.v) chk($sformatf("v%0d_pc", e.idx), ifid_pc, e.pc);
    end
    chk("tbl_fetch", fetch_cnt, 32'd11);
    chk("tbl_stall", stall_cnt, 32'd4);
    chk("tbl_flush", flush_cnt, 32'd5);

    // Counter saturation on the CNT_W=4 instance
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 0, 0);
    chk("fetch_21",    fetch_cnt, 32'd21);
    chk("sat_fetch",   {28'b0, sat_fetch}, 32'd15);
    for (int i = 0; i < 12; i++) cycle(1, 1, 0, 0, 0, 0);
    chk("stall_16",    stall_cnt, 32'd16);
    chk("sat_stall",   {28'b0, sat_stall}, 32'd15);
    for (int i = 0; i < 11; i++) cycle(0, 0, 1, 32'h200, 0, 0);
    chk("flush_16",    flush_cnt, 32'd16);
    chk("sat_flush",   {28'b0, sat_flush}, 32'd15);

    // PC wrap through the top of the address space
    @(negedge clk);
    drive(0, 0, 1, 32'hFFFF_FFF8, 0, 0);
    #1 chk("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1 chk("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_bubble", {31'b0, ifid_valid}, 32'h0);
    @(negedge clk);
    #1 chk("wrap_addr2", imem_addr, 32'h0);
    chk("wrap_pc0",    ifid_pc,    32'hFFFF_FFF8);
    chk("wrap_instr0", ifid_instr, 32'h4000_0FFE);
    @(negedge clk);
    #1 chk("wrap_addr3", imem_addr, 32'h4);
    chk("wrap_pc1",    ifid_pc,    32'hFFFF_FFFC);
    chk("wrap_instr1", ifid_instr, 32'h4000_0FFF);

    // Asynchronous reset between clock edges
    #2 arst_n = 1'b0;
    #1;
    chk("mrst_addr",  imem_addr, 32'h0);
    chk("mrst_pc",    ifid_pc,   32'h0);
    chk("mrst_valid", {31'b0, ifid_valid}, 32'h0);
    chk("mrst_instr", ifid_instr, 32'h0);
    chk("mrst_fetch", fetch_cnt, 32'h0);
    chk("mrst_stall", stall_cnt, 32'h0);
    chk("mrst_flush", flush_cnt, 32'h0);
    chk("mrst_sat",   {28'b0, sat_fetch}, 32'h0);
    @(posedge clk);
    #3 arst_n = 1'b1;
    @(negedge clk);
    #1 chk("boot_addr", imem_addr, 32'h0);
    @(posedge clk);
    #1 chk("boot_valid", {31'b0, ifid_valid}, 32'h0);
    chk("boot_fetch", fetch_cnt, 32'h0);
    @(negedge clk);
    #1 chk("run_addr", imem_addr, 32'h4);
    @(posedge clk);
    #1;
    chk("run_pc",    ifid_pc,    32'h0);
    chk("run_instr", ifid_instr, 32'h1000);
    chk("run_valid", {31'b0, ifid_valid}, 32'h1);
    chk("run_fetch", fetch_cnt,  32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
